alu_instr_sequencer: RTL and testbench
======================================

Name: alu_instr_sequencer

Overview:
- Multi-cycle control sequencer for the Phase 1 bus datapath (PC, MAR, MDR, IR, Y, Z, HI/LO, R0–R15, 32-bit ALU).
- Fetches one instruction per `start` request, then executes one register-register ALU instruction: add, sub, and, or, shifts, rotates, mul, div, neg and not.
- Drives every bus-select and register-enable strobe that the hand-written phase testbenches drive today.
- Waits on memory and on the multi-cycle ALU ops through handshakes.

Parameters:
- OPW, 5, opcode width.
- NREG, 16, number of general registers; sets the one-hot select width.
- ALU_TIMEOUT, 64, maximum cycles spent in EXEC waiting for `alu_done` before aborting.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous active-high reset.
- start  in  1  begin a fetch/execute; sampled only in IDLE.
- mem_ready  in  1  memory read data valid on Mdatain.
- alu_done  in  1  multi-cycle ALU (mul/div) result valid.
- ir_opcode  in  OPW  IR[31:27].
- ir_ra  in  4  IR[26:23].
- ir_rb  in  4  IR[22:19].
- ir_rc  in  4  IR[18:15].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- illegal  out  1  one-cycle pulse on unsupported opcode or ALU timeout.
- pc_out, mar_in, inc_pc, pc_in, mem_read, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in  out  1 each  datapath strobes.
- reg_out  out  NREG  one-hot register-to-bus enable.
- reg_in  out  NREG  one-hot bus-to-register enable.
- alu_op  out  OPW  operation presented to the ALU; 0 when not in EXEC.

Behaviour:
- Moore machine. All outputs are decoded from the state register only; no input-to-output combinational paths.
- On `clr`, immediately: state=IDLE and all outputs 0. Asserting `clr` mid-sequence discards the instruction; no partial writeback is ever issued after reset.
- Opcode map:
  - add 00011, sub 00100, and 00101, or 00110.
  - ror 00111, rol 01000, shr 01001, shra 01010, shl 01011.
  - div 01111, mul 10000, neg 10001, not 10010.
  - All other opcodes are illegal.
- States and strobes:
  - IDLE: no strobes. `start` → T0.
  - T0: pc_out, mar_in, inc_pc, z_in. → T1.
  - T1: zlow_out, pc_in, mem_read, mdr_in.
    - pc_in is asserted only in the first T1 cycle.
    - Stay in T1 while mem_ready=0; mem_read and mdr_in stay high throughout.
    - mem_ready=1 → T2.
  - T2: mdr_out, ir_in. → DECODE.
  - DECODE: no strobes; IR fields are now stable.
    - Illegal opcode → ERR.
    - neg/not → EXEC.
    - Otherwise → T3.
  - T3: reg_out[rb], y_in. → EXEC.
  - EXEC: alu_op=ir_opcode, z_in.
    - Bus source for two-operand ops: reg_out[rc].
    - Bus source for neg/not: reg_out[rb].
    - Single-cycle ops leave after 1 cycle.
    - mul/div stay until alu_done=1, with z_in held high.
    - A wait counter counts EXEC cycles. On reaching ALU_TIMEOUT → ERR.
    - Exit: mul/div → WB_LO; all others → WB.
  - WB: zlow_out, reg_in[ra]. → DONE.
  - WB_LO: zlow_out, lo_in. → WB_HI.
  - WB_HI: zhigh_out, hi_in. → DONE.
  - DONE: done=1. → IDLE.
  - ERR: illegal=1. → IDLE, with no register or HI/LO write.
- reg_out and reg_in are each at most one-hot and never both nonzero in the same cycle. Writing R0 is allowed; R0 handling belongs to the register file.
- At most one bus driver per cycle: pc_out, zlow_out, zhigh_out, mdr_out, or a reg_out bit.
- `start` outside IDLE is ignored; no queuing.
- `start` in DONE or ERR is ignored; a new request must be presented in IDLE.
- The wait counter clears on entry to EXEC. The timeout compare is ≥ ALU_TIMEOUT.
- Latency from `start` to `done`, with mem_ready=1 and alu_done already high:
  - two-operand single-cycle op: 8 cycles.
  - neg/not: 7 cycles.
  - mul/div: 9 cycles.
- Each extra memory wait cycle adds 1 cycle; each extra ALU wait cycle adds 1 cycle.

Test Plan:
- Reset mid-sequence: assert clr during T1 → next sample shows busy=0, all strobes 0, no reg_in pulse afterwards; a subsequent `start` runs a full fetch.
- add R5,R2,R3 (IR=0x1A918000), mem_ready tied 1 → done 8 cycles after start.
  - reg_out[2] with y_in in T3.
  - reg_out[3] with alu_op=00011 and z_in in EXEC.
  - reg_in[5] with zlow_out in WB.
- not R4,R7 (opcode 10010, ra=4, rb=7) → no T3 or y_in pulse; EXEC drives reg_out[7] with alu_op=10010; reg_in[4] pulses; done 7 cycles after start.
- mul R3,R1, mem_ready low 3 cycles, alu_done asserted 5 cycles after EXEC entry →
  - T1 held 4 cycles.
  - lo_in then hi_in on consecutive cycles.
  - reg_in stays 0 throughout.
  - done 17 cycles after start.
- div with alu_done held 0 → illegal pulses after 64 EXEC cycles; lo_in, hi_in and reg_in never asserted; busy drops the next cycle.
- Opcode 00000 (ld), then `start` pulsed while in DECODE → illegal pulse, return to IDLE; the mid-sequence start does not launch a second fetch.

Source files
------------

// File: rtl/alu_instr_sequencer.sv
// Multi-cycle fetch/execute control sequencer for the bus datapath.
// Fetches one instruction per start request and runs one register-register ALU op.
// All outputs are registered and decoded from the next state, so they track the
// state register with no input-to-output combinational paths.
module alu_instr_sequencer #(
    parameter int unsigned OPW         = 5,
    parameter int unsigned NREG        = 16,
    parameter int unsigned ALU_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic            mem_ready,
    input  logic            alu_done,
    input  logic [OPW-1:0]  ir_opcode,
    input  logic [3:0]      ir_ra,
    input  logic [3:0]      ir_rb,
    input  logic [3:0]      ir_rc,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic            pc_out,
    output logic            mar_in,
    output logic            inc_pc,
    output logic            pc_in,
    output logic            mem_read,
    output logic            mdr_in,
    output logic            mdr_out,
    output logic            ir_in,
    output logic            y_in,
    output logic            z_in,
    output logic            zlow_out,
    output logic            zhigh_out,
    output logic            lo_in,
    output logic            hi_in,
    output logic [NREG-1:0] reg_out,
    output logic [NREG-1:0] reg_in,
    output logic [OPW-1:0]  alu_op
);

    localparam logic [OPW-1:0] OpAdd  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OpSub  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OpAnd  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OpOr   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OpRor  = OPW'(5'b00111);
    localparam logic [OPW-1:0] OpRol  = OPW'(5'b01000);
    localparam logic [OPW-1:0] OpShr  = OPW'(5'b01001);
    localparam logic [OPW-1:0] OpShra = OPW'(5'b01010);
    localparam logic [OPW-1:0] OpShl  = OPW'(5'b01011);
    localparam logic [OPW-1:0] OpDiv  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OpMul  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OpNeg  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OpNot  = OPW'(5'b10010);

    localparam int unsigned     CntW    = $clog2(ALU_TIMEOUT + 1);
    // Count value seen in the last EXEC cycle allowed before aborting.
    localparam logic [CntW-1:0] CntLast = CntW'(ALU_TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT2, StDecode, StT3, StExec,
        StWb, StWbLo, StWbHi, StDone, StErr
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic op_legal, op_unary, op_multi;
    logic [NREG-1:0] sel_ra, sel_rb, sel_rc;

    logic busy_d, done_d, illegal_d;
    logic pc_out_d, mar_in_d, inc_pc_d, pc_in_d, mem_read_d, mdr_in_d, mdr_out_d, ir_in_d;
    logic y_in_d, z_in_d, zlow_out_d, zhigh_out_d, lo_in_d, hi_in_d;
    logic [NREG-1:0] reg_out_d, reg_in_d;
    logic [OPW-1:0]  alu_op_d;

    // Opcode classification and one-hot register selects from the IR fields.
    always_comb begin
        op_legal = 1'b0;
        op_unary = 1'b0;
        op_multi = 1'b0;
        case (ir_opcode)
            OpAdd, OpSub, OpAnd, OpOr, OpRor, OpRol, OpShr, OpShra, OpShl: op_legal = 1'b1;
            OpDiv, OpMul: begin
                op_legal = 1'b1;
                op_multi = 1'b1;
            end
            OpNeg, OpNot: begin
                op_legal = 1'b1;
                op_unary = 1'b1;
            end
            default: op_legal = 1'b0;
        endcase
        sel_ra = {{(NREG-1){1'b0}}, 1'b1} << ir_ra;
        sel_rb = {{(NREG-1){1'b0}}, 1'b1} << ir_rb;
        sel_rc = {{(NREG-1){1'b0}}, 1'b1} << ir_rc;
    end

    // Next-state and EXEC wait counter.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StT0;
            StT0:     state_d = StT1;
            StT1:     if (mem_ready) state_d = StT2;
            StT2:     state_d = StDecode;
            StDecode: begin
                if (!op_legal)     state_d = StErr;
                else if (op_unary) state_d = StExec;
                else               state_d = StT3;
            end
            StT3:     state_d = StExec;
            StExec: begin
                if (!op_multi)             state_d = StWb;
                else if (alu_done)         state_d = StWbLo;
                else if (cnt_q >= CntLast) state_d = StErr;
                else                       state_d = StExec;
            end
            StWb:     state_d = StDone;
            StWbLo:   state_d = StWbHi;
            StWbHi:   state_d = StDone;
            StDone:   state_d = StIdle;
            StErr:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // Counter sits at zero outside EXEC, so it is clear on every EXEC entry.
        cnt_d = (state_q == StExec) ? cnt_q + 1'b1 : '0;
    end

    // Output decode from the next state; registered below.
    always_comb begin
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
        illegal_d   = (state_d == StErr);
        pc_out_d    = (state_d == StT0);
        mar_in_d    = (state_d == StT0);
        inc_pc_d    = (state_d == StT0);
        z_in_d      = (state_d == StT0) || (state_d == StExec);
        zlow_out_d  = (state_d == StT1) || (state_d == StWb) || (state_d == StWbLo);
        // PC reload only on the first T1 cycle, not while waiting on memory.
        pc_in_d     = (state_d == StT1) && (state_q == StT0);
        mem_read_d  = (state_d == StT1);
        mdr_in_d    = (state_d == StT1);
        mdr_out_d   = (state_d == StT2);
        ir_in_d     = (state_d == StT2);
        y_in_d      = (state_d == StT3);
        lo_in_d     = (state_d == StWbLo);
        zhigh_out_d = (state_d == StWbHi);
        hi_in_d     = (state_d == StWbHi);
        reg_out_d   = '0;
        reg_in_d    = '0;
        alu_op_d    = '0;
        if (state_d == StT3) begin
            reg_out_d = sel_rb;
        end
        if (state_d == StExec) begin
            reg_out_d = op_unary ? sel_rb : sel_rc;
            alu_op_d  = ir_opcode;
        end
        if (state_d == StWb) begin
            reg_in_d = sel_ra;
        end
    end

    // State, counter and registered outputs; clr drops everything at once.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
            pc_out    <= 1'b0;
            mar_in    <= 1'b0;
            inc_pc    <= 1'b0;
            pc_in     <= 1'b0;
            mem_read  <= 1'b0;
            mdr_in    <= 1'b0;
            mdr_out   <= 1'b0;
            ir_in     <= 1'b0;
            y_in      <= 1'b0;
            z_in      <= 1'b0;
            zlow_out  <= 1'b0;
            zhigh_out <= 1'b0;
            lo_in     <= 1'b0;
            hi_in     <= 1'b0;
            reg_out   <= '0;
            reg_in    <= '0;
            alu_op    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy      <= busy_d;
            done      <= done_d;
            illegal   <= illegal_d;
            pc_out    <= pc_out_d;
            mar_in    <= mar_in_d;
            inc_pc    <= inc_pc_d;
            pc_in     <= pc_in_d;
            mem_read  <= mem_read_d;
            mdr_in    <= mdr_in_d;
            mdr_out   <= mdr_out_d;
            ir_in     <= ir_in_d;
            y_in      <= y_in_d;
            z_in      <= z_in_d;
            zlow_out  <= zlow_out_d;
            zhigh_out <= zhigh_out_d;
            lo_in     <= lo_in_d;
            hi_in     <= hi_in_d;
            reg_out   <= reg_out_d;
            reg_in    <= reg_in_d;
            alu_op    <= alu_op_d;
        end
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed self-checking bench for alu_instr_sequencer.
module tb_alu_instr_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        start, mem_ready, alu_done;
    logic [4:0]  ir_opcode;
    logic [3:0]  ir_ra, ir_rb, ir_rc;
    logic        busy, done, illegal;
    logic        pc_out, mar_in, inc_pc, pc_in, mem_read, mdr_in, mdr_out, ir_in;
    logic        y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in;
    logic [15:0] reg_out, reg_in;
    logic [4:0]  alu_op;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-run observations.
    int          done_n, ill_n, lo_n, hi_n;
    int          t1_cnt, pc_in_cnt, y_cnt, exec_cnt, regin_cnt, viol;
    logic [15:0] y_regout, exec_regout, regin_val;
    logic [4:0]  exec_op;
    logic        regin_zlow, exec_zin;

    alu_instr_sequencer #(
        .OPW(5),
        .NREG(16),
        .ALU_TIMEOUT(64)
    ) dut (
        .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .alu_done(alu_done),
        .ir_opcode(ir_opcode), .ir_ra(ir_ra), .ir_rb(ir_rb), .ir_rc(ir_rc),
        .busy(busy), .done(done), .illegal(illegal),
        .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in),
        .mem_read(mem_read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
        .y_in(y_in), .z_in(z_in), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
        .lo_in(lo_in), .hi_in(hi_in), .reg_out(reg_out), .reg_in(reg_in), .alu_op(alu_op)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] strobes();
        return {pc_out, mar_in, inc_pc, pc_in, mem_read, mdr_in, mdr_out, ir_in,
                y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one instruction and observe it cycle by cycle until done/illegal.
    // Cycle n is the n-th cycle after the start cycle; memory stalls for
    // mr_lo..mr_hi, alu_done rises at cycle ad_at, start re-pulses at restart_at.
    task automatic run_instr(input logic [31:0] ir, input int mr_lo, input int mr_hi,
                             input int ad_at, input int restart_at, input int max_n);
        ir_opcode = ir[31:27];
        ir_ra     = ir[26:23];
        ir_rb     = ir[22:19];
        ir_rc     = ir[18:15];
        done_n = -1; ill_n = -1; lo_n = -1; hi_n = -1;
        t1_cnt = 0; pc_in_cnt = 0; y_cnt = 0; exec_cnt = 0; regin_cnt = 0; viol = 0;
        y_regout = '0; exec_regout = '0; regin_val = '0; exec_op = '0;
        regin_zlow = 1'b0; exec_zin = 1'b1;
        start     = 1'b1;
        mem_ready = 1'b1;
        alu_done  = (ad_at <= 0);
        for (int n = 1; n <= max_n; n++) begin
            step();
            start     = (n == restart_at);
            mem_ready = !(n >= mr_lo && n <= mr_hi);
            alu_done  = (n >= ad_at);
            t1_cnt    += int'(mem_read);
            pc_in_cnt += int'(pc_in);
            if (y_in) begin
                y_cnt++;
                y_regout = reg_out;
            end
            if (alu_op != 5'd0) begin
                exec_cnt++;
                exec_regout = reg_out;
                exec_op     = alu_op;
                exec_zin    = exec_zin & z_in;
            end
            if (reg_in != 16'd0) begin
                regin_cnt++;
                regin_val  = reg_in;
                regin_zlow = zlow_out;
            end
            if (lo_in) lo_n = n;
            if (hi_in) hi_n = n;
            if (!$onehot0(reg_out) || !$onehot0(reg_in) || (reg_out != 0 && reg_in != 0))
                viol++;
            if (int'(pc_out) + int'(zlow_out) + int'(zhigh_out) + int'(mdr_out)
                + int'(reg_out != 16'd0) > 1)
                viol++;
            if (done && done_n < 0) done_n = n;
            if (illegal && ill_n < 0) ill_n = n;
            if (done || illegal) break;
        end
        start = 1'b0;
    endtask

    initial begin
        logic busy_seen;
        logic [15:0] regin_seen;
        clr = 1'b1; start = 1'b0; mem_ready = 1'b1; alu_done = 1'b0;
        ir_opcode = '0; ir_ra = '0; ir_rb = '0; ir_rc = '0;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_illegal", illegal, 0);
        check_eq("rst_strobes", strobes(), 0);
        check_eq("rst_reg_out", reg_out, 0);
        check_eq("rst_reg_in", reg_in, 0);
        check_eq("rst_alu_op", alu_op, 0);
        step(); step();
        clr = 1'b0;
        step();

        // Reset mid-sequence while stalled in T1.
        ir_opcode = 5'b00011; ir_ra = 4'd5; ir_rb = 4'd2; ir_rc = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        mem_ready = 1'b0;
        check_eq("mid_t0_pc_out", pc_out, 1);
        step();
        check_eq("mid_t1_mem_read", mem_read, 1);
        #2 clr = 1'b1;
        #1;
        check_eq("mid_clr_busy", busy, 0);
        check_eq("mid_clr_strobes", strobes(), 0);
        check_eq("mid_clr_regs", {reg_out, reg_in}, 0);
        step();
        clr = 1'b0;
        mem_ready = 1'b1;
        busy_seen = 1'b0;
        regin_seen = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            busy_seen  = busy_seen | busy;
            regin_seen = regin_seen | reg_in;
        end
        check_eq("post_clr_busy", busy_seen, 0);
        check_eq("post_clr_reg_in", regin_seen, 0);

        // add R5,R2,R3 after reset: full fetch, 8 cycles.
        run_instr(32'h1A91_8000, 0, 0, 0, -1, 30);
        check_eq("add_done_lat", done_n, 8);
        check_eq("add_pc_in_cnt", pc_in_cnt, 1);
        check_eq("add_y_cnt", y_cnt, 1);
        check_eq("add_t3_reg_out", y_regout, 16'h0004);
        check_eq("add_exec_reg_out", exec_regout, 16'h0008);
        check_eq("add_exec_op", exec_op, 5'b00011);
        check_eq("add_exec_z_in", exec_zin, 1);
        check_eq("add_wb_reg_in", regin_val, 16'h0020);
        check_eq("add_wb_zlow", regin_zlow, 1);
        check_eq("add_invariants", viol, 0);
        step();
        check_eq("add_idle_busy", busy, 0);

        // not R4,R7: no T3, 7 cycles.
        run_instr({5'b10010, 4'd4, 4'd7, 4'd0, 15'd0}, 0, 0, 0, -1, 30);
        check_eq("not_done_lat", done_n, 7);
        check_eq("not_y_cnt", y_cnt, 0);
        check_eq("not_exec_reg_out", exec_regout, 16'h0080);
        check_eq("not_exec_op", exec_op, 5'b10010);
        check_eq("not_wb_reg_in", regin_val, 16'h0010);
        check_eq("not_invariants", viol, 0);
        step();

        // mul R3,R1 with 3 memory stall cycles and alu_done 5 cycles into EXEC.
        run_instr({5'b10000, 4'd3, 4'd1, 4'd2, 15'd0}, 2, 4, 14, -1, 40);
        check_eq("mul_t1_len", t1_cnt, 4);
        check_eq("mul_pc_in_cnt", pc_in_cnt, 1);
        check_eq("mul_exec_len", exec_cnt, 6);
        check_eq("mul_exec_z_in", exec_zin, 1);
        check_eq("mul_lo_cycle", lo_n, 15);
        check_eq("mul_hi_cycle", hi_n, 16);
        check_eq("mul_reg_in_cnt", regin_cnt, 0);
        check_eq("mul_done_lat", done_n, 17);
        check_eq("mul_invariants", viol, 0);
        step();

        // div with alu_done held low: timeout after 64 EXEC cycles.
        run_instr({5'b01111, 4'd6, 4'd8, 4'd9, 15'd0}, 0, 0, 100000, -1, 90);
        check_eq("div_exec_len", exec_cnt, 64);
        check_eq("div_illegal_cycle", ill_n, 70);
        check_eq("div_no_done", done_n, -1);
        check_eq("div_no_lo_hi", {lo_n != -1, hi_n != -1}, 0);
        check_eq("div_reg_in_cnt", regin_cnt, 0);
        step();
        check_eq("div_busy_after", busy, 0);

        // Opcode 00000 with start re-pulsed during DECODE.
        run_instr({5'b00000, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 0, 0, 4, 30);
        check_eq("ld_illegal_cycle", ill_n, 5);
        check_eq("ld_no_exec", exec_cnt, 0);
        check_eq("ld_reg_in_cnt", regin_cnt, 0);
        step();
        check_eq("ld_idle_busy", busy, 0);
        step();
        check_eq("ld_no_refetch", {busy, pc_out, mem_read}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
